// File: rtl/instr_mem_256.sv
// instr_mem_256: 64 x 32-bit (256-byte) instruction memory for the MIPS fetch path.
//
// Ports:
//   clk       system clock; writes commit on the rising edge
//   reset     asynchronous active-low reset; clears every word to NOP (0)
//   addr      fetch byte address (PC[7:0]); word index addr[7:2]
//   dout      combinational instruction word at addr[7:2]
//   misalign  high when addr[1:0] != 0 (informational, does not affect dout)
//   we        write enable, sampled at the rising edge of clk
//   waddr     write byte address; word index waddr[7:2], low bits ignored
//   wdata     write data
//   wbe       byte enables, wbe[3] -> bits 31:24 ... wbe[0] -> bits 7:0
module instr_mem_256 (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  addr,
    output logic [31:0] dout,
    output logic        misalign,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe
);

    localparam int unsigned Depth = 64;

    logic [31:0] mem_q [Depth];
    logic        wr_armed_q;
    logic [5:0]  rd_idx;
    logic [5:0]  wr_idx;
    logic        wr_commit;
    logic [31:0] wr_word_d;

    // Byte-offset bits of the write address select nothing.
    logic unused_waddr_lo;
    assign unused_waddr_lo = ^waddr[1:0];

    assign rd_idx = addr[7:2];
    assign wr_idx = waddr[7:2];

    // Writes are held off for the first edge after reset release, so an edge that
    // coincides with the release of reset can never commit a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_armed_q <= 1'b0;
        end else begin
            wr_armed_q <= 1'b1;
        end
    end

    assign wr_commit = wr_armed_q && we && (wbe != 4'b0000);

    // Merge enabled lanes of wdata into the addressed word; other lanes keep their value.
    always_comb begin
        wr_word_d = mem_q[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
                wr_word_d[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (wr_commit) begin
            mem_q[wr_idx] <= wr_word_d;
        end
    end

    // The array is already zero during reset; gating keeps dout at NOP even while the
    // asynchronous clear is propagating.
    always_comb begin
        dout     = reset ? mem_q[rd_idx] : 32'h0000_0000;
        misalign = |addr[1:0];
    end

endmodule

// File: tb/tb_instr_mem_256.sv
module tb_instr_mem_256;

    logic        clk;
    logic        reset;
    logic [7:0]  addr;
    logic [31:0] dout;
    logic        misalign;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;

    instr_mem_256 dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .dout     (dout),
        .misalign (misalign),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wbe      (wbe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] dout;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   total = 0;
    int   bad   = 0;

    // Monitor: samples the outputs 1 ns after each read request and compares against
    // the oldest expectation in the scoreboard.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: read presented with no expectation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (dout !== e.dout) begin
                    bad++;
                    $display("FAIL %s dout: got %08h want %08h", e.name, dout, e.dout);
                end
                total++;
                if (misalign !== e.mis) begin
                    bad++;
                    $display("FAIL %s misalign: got %0b want %0b", e.name, misalign, e.mis);
                end
            end
        end
    end

    // Present a read address and queue the hand-computed expected response.
    task automatic chk(input string name, input logic [7:0] a, input logic [31:0] ed,
                       input logic em);
        exp_t e;
        addr = a;
        e.name = name;
        e.dout = ed;
        e.mis  = em;
        exp_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        wbe   = be;
        @(posedge clk);
        #1;
        we = 1'b0;
        wbe = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        addr  = 8'h00;
        we    = 1'b0;
        waddr = 8'h00;
        wdata = 32'h0;
        wbe   = 4'h0;

        // Reset state
        @(negedge clk);
        chk("rst_w0", 8'h00, 32'h0, 1'b0);
        chk("rst_w63", 8'hFF, 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);  // arming edge after release

        // Reset clear, asynchronous, mid-cycle
        wr(8'h14, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("pre_clear", 8'h14, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        chk("async_clear", 8'h14, 32'h0, 1'b0);
        chk("async_clear_mis", 8'h15, 32'h0, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);

        // Full-word writes
        wr(8'h00, 32'h3C010000, 4'hF);
        wr(8'h04, 32'h34210004, 4'hF);
        @(negedge clk);
        chk("full_w0", 8'h00, 32'h3C010000, 1'b0);
        chk("full_w1", 8'h04, 32'h34210004, 1'b0);

        // Byte-lane write, plus we with no lanes enabled
        wr(8'h0C, 32'h11223344, 4'hF);
        wr(8'h0C, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        chk("byte_lane", 8'h0C, 32'h11BB33DD, 1'b0);
        wr(8'h0E, 32'hFFFFFFFF, 4'b0000);
        @(negedge clk);
        chk("zero_wbe", 8'h0C, 32'h11BB33DD, 1'b0);
        wr(8'h0F, 32'h99000000, 4'b1000);
        @(negedge clk);
        chk("hi_lane_waddr_lo", 8'h0D, 32'h99BB33DD, 1'b1);

        // Misaligned and wrap addressing
        wr(8'hFC, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        chk("addr_fe", 8'hFE, 32'hCAFEF00D, 1'b1);
        chk("addr_fc", 8'hFC, 32'hCAFEF00D, 1'b0);
        chk("addr_01", 8'h01, 32'h3C010000, 1'b1);

        // Read-during-write on the same word
        wr(8'h10, 32'h00000001, 4'hF);
        @(negedge clk);
        addr  = 8'h10;
        we    = 1'b1;
        waddr = 8'h13;
        wdata = 32'h00000002;
        wbe   = 4'hF;
        chk("rdw_before", 8'h10, 32'h00000001, 1'b0);
        @(posedge clk);
        #1;
        we  = 1'b0;
        wbe = 4'h0;
        chk("rdw_after", 8'h10, 32'h00000002, 1'b0);

        // Reset dominance over writes
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b1;
        wbe   = 4'hF;
        waddr = 8'h20;
        wdata = 32'h00000077;
        repeat (3) @(posedge clk);
        #1;
        chk("dom_w8", 8'h20, 32'h0, 1'b0);
        chk("dom_w0", 8'h00, 32'h0, 1'b0);
        chk("dom_w63", 8'hFC, 32'h0, 1'b0);
        @(negedge clk);
        #5 reset = 1'b1;  // coincident with the rising edge
        #1;
        chk("coincident_edge", 8'h20, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        we  = 1'b0;
        wbe = 4'h0;
        chk("next_edge_writes", 8'h20, 32'h00000077, 1'b0);
        chk("other_word_zero", 8'h24, 32'h0, 1'b0);

        #10;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
